// File: rtl/button_pkg.sv
`default_nettype none
// ============================================================================
// Module      : button_pkg
// Description : Shared constants for the button manager: register indices,
//               AHB transfer encoding and bit positions of register fields.
// Revision    : 1.0 - initial release
// ============================================================================
package button_pkg;

  // Register index, taken from HADDR[3:2]
  localparam logic [1:0] FLAG_MODE_IDX = 2'd0;
  localparam logic [1:0] FLAG_TRIP_IDX = 2'd1;
  localparam logic [1:0] STATUS_IDX    = 2'd2;
  localparam logic [1:0] CLEAR_IDX     = 2'd3;

  // AHB IDLE transfer type
  localparam logic [1:0] HTRANS_IDLE = 2'b00;

  // Status register field positions
  localparam int STAT_MODE_LVL_BIT = 0;
  localparam int STAT_TRIP_LVL_BIT = 1;
  localparam int STAT_MODE_CNT_LSB = 8;
  localparam int STAT_TRIP_CNT_LSB = 16;

  // Clear register field positions
  localparam int CLR_MODE_BIT = 0;
  localparam int CLR_TRIP_BIT = 1;
  localparam int CLR_CNT_BIT  = 2;

endpackage
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// Module      : button_debounce
// Description : Two-flop synchroniser, stability counter and debounced level
//               for one active-low button. rise_pulse is a one-cycle strobe
//               registered on the edge the debounced level goes to pressed.
// Revision    : 1.0 - initial release
// ============================================================================
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic level,
  output logic rise_pulse
);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             rise_q,  rise_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             pressed;

  // Synchronise the raw pin and count consecutive samples that disagree with
  // the debounced level; any agreeing sample restarts the count.
  always_comb begin
    sync1_d = btn_n;
    sync2_d = sync1_q;
    pressed = ~sync2_q;
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    if (pressed != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = ~level_q;
        rise_d  = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers; synchronisers reset to the released pin level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level      = level_q;
  assign rise_pulse = rise_q;

endmodule
`default_nettype wire

// File: rtl/button_manager.sv
`default_nettype none
// ============================================================================
// Module      : button_manager
// Description : AHB-Lite slave that debounces the Mode and Trip buttons and
//               latches press flags and 8-bit press counts for CPU polling.
// Revision    : 1.0 - initial release
// ============================================================================
module button_manager
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 10
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  input  logic        HWRITE,
  input  logic        HREADY,
  input  logic        HSEL,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  input  logic        nMode,
  input  logic        nTrip
);

  logic       mode_level, mode_rise;
  logic       trip_level, trip_rise;
  logic [1:0] addr_q, addr_d;
  logic       rd_q, rd_d;
  logic       wr_q, wr_d;
  logic       mode_flag_q, mode_flag_d;
  logic       trip_flag_q, trip_flag_d;
  logic [7:0] mode_cnt_q, mode_cnt_d;
  logic [7:0] trip_cnt_q, trip_cnt_d;
  logic       addr_phase, clr_write, clr_mode, clr_trip, clr_cnt;
  logic       unused_bits;

  assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HWDATA[31:3], HSIZE};
  assign HREADYOUT   = 1'b1;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_mode (
    .clk(HCLK), .rst_n(HRESETn), .btn_n(nMode),
    .level(mode_level), .rise_pulse(mode_rise)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_trip (
    .clk(HCLK), .rst_n(HRESETn), .btn_n(nTrip),
    .level(trip_level), .rise_pulse(trip_rise)
  );

  // Address-phase capture and flag/count updates; a press event beats any
  // flag clear on the same edge, while a count clear beats an increment.
  always_comb begin
    addr_phase = HSEL && HREADY && (HTRANS != HTRANS_IDLE);
    addr_d     = addr_phase ? HADDR[3:2] : 2'b00;
    wr_d       = addr_phase && HWRITE;
    rd_d       = addr_phase && !HWRITE;

    clr_write  = wr_q && (addr_q == CLEAR_IDX);
    clr_mode   = (rd_q && (addr_q == FLAG_MODE_IDX)) || (clr_write && HWDATA[CLR_MODE_BIT]);
    clr_trip   = (rd_q && (addr_q == FLAG_TRIP_IDX)) || (clr_write && HWDATA[CLR_TRIP_BIT]);
    clr_cnt    = clr_write && HWDATA[CLR_CNT_BIT];

    mode_flag_d = mode_rise || (mode_flag_q && !clr_mode);
    trip_flag_d = trip_rise || (trip_flag_q && !clr_trip);

    mode_cnt_d = mode_cnt_q;
    if (clr_cnt)        mode_cnt_d = 8'd0;
    else if (mode_rise) mode_cnt_d = mode_cnt_q + 8'd1;

    trip_cnt_d = trip_cnt_q;
    if (clr_cnt)        trip_cnt_d = 8'd0;
    else if (trip_rise) trip_cnt_d = trip_cnt_q + 8'd1;
  end

  // Read data is driven only while a read data phase is in progress
  always_comb begin
    HRDATA = 32'd0;
    if (rd_q) begin
      case (addr_q)
        FLAG_MODE_IDX: HRDATA[0] = mode_flag_q;
        FLAG_TRIP_IDX: HRDATA[0] = trip_flag_q;
        STATUS_IDX: begin
          HRDATA[STAT_MODE_LVL_BIT]                    = mode_level;
          HRDATA[STAT_TRIP_LVL_BIT]                    = trip_level;
          HRDATA[STAT_MODE_CNT_LSB +: 8]               = mode_cnt_q;
          HRDATA[STAT_TRIP_CNT_LSB +: 8]               = trip_cnt_q;
        end
        default: HRDATA = 32'd0;
      endcase
    end
  end

  // Bus-phase latches, flags and counters
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      addr_q      <= 2'b00;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      mode_flag_q <= 1'b0;
      trip_flag_q <= 1'b0;
      mode_cnt_q  <= 8'd0;
      trip_cnt_q  <= 8'd0;
    end else begin
      addr_q      <= addr_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      mode_flag_q <= mode_flag_d;
      trip_flag_q <= trip_flag_d;
      mode_cnt_q  <= mode_cnt_d;
      trip_cnt_q  <= trip_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_button_manager.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_manager
// Description : Directed self-checking bench for button_manager with a short
//               debounce window (DEBOUNCE_CYCLES = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_manager;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic        HWRITE;
  logic        HREADY;
  logic        HSEL;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        nMode;
  logic        nTrip;

  int n_checks = 0;
  int n_fail   = 0;

  button_manager #(.DEBOUNCE_CYCLES(4), .CNT_W(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HWDATA(HWDATA),
    .HWRITE(HWRITE), .HREADY(HREADY), .HSEL(HSEL), .HSIZE(HSIZE),
    .HTRANS(HTRANS), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT),
    .nMode(nMode), .nTrip(nTrip)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge
  task automatic tick(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic bus_idle();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = 32'd0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
    tick(1);
    bus_idle();
    #3;
    d = HRDATA;
    check("hreadyout", {31'd0, HREADYOUT}, 32'd1);
    tick(1);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] v);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
    tick(1);
    bus_idle();
    HWDATA = v;
    tick(1);
    HWDATA = 32'd0;
  endtask

  task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(tag, d, exp);
  endtask

  task automatic press_mode();
    nMode = 1'b0; tick(7);
    nMode = 1'b1; tick(7);
  endtask

  initial begin
    HRESETn = 1'b0; HADDR = 32'd0; HWDATA = 32'd0; HWRITE = 1'b0;
    HREADY = 1'b1; HSEL = 1'b0; HSIZE = 3'b010; HTRANS = 2'b00;
    nMode = 1'b1; nTrip = 1'b1;
    tick(3);
    HRESETn = 1'b1;

    // Reset state
    check("rst_hrdata", HRDATA, 32'd0);
    check("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
    rd_check("rst_flag_mode", 32'h0, 32'd0);
    rd_check("rst_flag_trip", 32'h4, 32'd0);
    rd_check("rst_status", 32'h8, 32'd0);

    // Mode press: watch status every cycle to pin down the latency
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h8;
    nMode = 1'b0;
    tick(6);
    check("mode_level_edge6", HRDATA, 32'h0000_0001);
    tick(1);
    check("mode_count_edge7", HRDATA, 32'h0000_0101);
    bus_idle();
    tick(12);
    rd_check("mode_flag_set", 32'h0, 32'd1);
    rd_check("mode_flag_r2c", 32'h0, 32'd0);
    rd_check("mode_status", 32'h8, 32'h0000_0101);
    nMode = 1'b1;
    tick(10);
    rd_check("mode_release", 32'h8, 32'h0000_0100);

    // Trip bouncing never debounces
    for (int i = 0; i < 15; i++) begin
      nTrip = 1'b0; tick(2);
      nTrip = 1'b1; tick(2);
    end
    tick(4);
    rd_check("bounce_status", 32'h8, 32'h0000_0100);
    rd_check("bounce_flag", 32'h4, 32'd0);
    nTrip = 1'b0;
    tick(10);
    rd_check("trip_status", 32'h8, 32'h0001_0102);
    rd_check("trip_flag", 32'h4, 32'd1);
    nTrip = 1'b1;
    tick(10);

    // Rise pulse coincides with the read data phase: set wins
    nMode = 1'b0;
    tick(5);
    rd_check("race_read", 32'h0, 32'd0);
    rd_check("race_after", 32'h0, 32'd1);
    nMode = 1'b1;
    tick(10);

    // Count clear, then wrap after 256 presses
    bus_write(32'hC, 32'h4);
    rd_check("cnt_clear", 32'h8, 32'd0);
    for (int i = 0; i < 255; i++) press_mode();
    rd_check("cnt_255", 32'h8, 32'h0000_FF00);
    press_mode();
    rd_check("cnt_wrap", 32'h8, 32'd0);

    // Writes to the flag register are ignored; 0xC clears are bit-selective
    bus_write(32'h0, 32'hFFFF_FFFF);
    bus_write(32'hC, 32'h2);
    rd_check("write_ignored", 32'h0, 32'd1);
    rd_check("read_clr_reg", 32'hC, 32'd0);
    press_mode();
    bus_write(32'hC, 32'h1);
    rd_check("write_clr_mode", 32'h0, 32'd0);

    // Count clear on the same edge as a Trip press event
    nTrip = 1'b0;
    tick(5);
    bus_write(32'hC, 32'h4);
    rd_check("clr_vs_press_cnt", 32'h8, 32'h0000_0002);
    rd_check("clr_vs_press_flag", 32'h4, 32'd1);
    nTrip = 1'b1;
    tick(10);

    // Simultaneous presses set both flags and counts
    nMode = 1'b0; nTrip = 1'b0;
    tick(8);
    nMode = 1'b1; nTrip = 1'b1;
    tick(8);
    rd_check("dual_status", 32'h8, 32'h0001_0100);

    // Reset mid-debounce with both flags set
    nMode = 1'b0;
    tick(4);
    HRESETn = 1'b0;
    tick(1);
    HRESETn = 1'b1;
    rd_check("mrst_flag_mode", 32'h0, 32'd0);
    rd_check("mrst_flag_trip", 32'h4, 32'd0);
    rd_check("mrst_status", 32'h8, 32'd0);
    rd_check("mrst_redebounce", 32'h8, 32'h0000_0101);
    rd_check("mrst_flag_after", 32'h0, 32'd1);
    nMode = 1'b1;
    tick(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit so the bench can never hang
  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL timeout: got running expected finished");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

endmodule
`default_nettype wire
